// File: rtl/tytra_stream_rx_fifo.sv
// tytra_stream_rx_fifo: first-word-fall-through receive FIFO for a FloPoCo stream with registered
// upstream ready that reserves SLACK words for data still in flight after ready falls.
module tytra_stream_rx_fifo #(
   parameter int STREAMW = 34,
   parameter int DEPTH   = 16,
   parameter int SLACK   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ivalid,
   input  logic [STREAMW-1:0]         idata,
   output logic                       up_ready,
   output logic                       ovalid,
   output logic [STREAMW-1:0]         odata,
   input  logic                       dn_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       exc_seen,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [STREAMW-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count_next;
   logic               full, push, pop;
   assign full   = count == CW'(DEPTH);
   assign ovalid = count != '0;
   assign odata  = mem[rd_ptr];
   assign pop    = ovalid & dn_ready;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push   = ivalid & (!full | pop);
   always_comb begin
      count_next = (push & !pop) ? count + 1'b1 : (pop & !push) ? count - 1'b1 : count;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         up_ready <= 1'b0;
         exc_seen <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count    <= count_next;
         up_ready <= (CW'(DEPTH) - count_next) > CW'(SLACK);
         if (push && idata[STREAMW-1:STREAMW-2] != 2'b01) exc_seen <= 1'b1;
         if (ivalid && full && !pop) overflow <= 1'b1;
      end
   end
   // storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= idata;
   end
endmodule

// File: tb/tb_tytra_stream_rx_fifo.sv
// tb_tytra_stream_rx_fifo: directed checks of fill, overflow, pass-through, latency, exceptions and reset.
module tb_tytra_stream_rx_fifo;
   logic        clk = 1'b0;
   logic        rst, ivalid, dn_ready;
   logic [33:0] idata;
   logic        up_ready, ovalid, exc_seen, overflow;
   logic [33:0] odata;
   logic [4:0]  count;
   int          total = 0;
   int          bad = 0;

   tytra_stream_rx_fifo dut (
      .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata), .up_ready(up_ready),
      .ovalid(ovalid), .odata(odata), .dn_ready(dn_ready), .count(count),
      .exc_seen(exc_seen), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ivalid = 1'b0; dn_ready = 1'b0; idata = '0;
      step(); step();
      check("rst_count", count, 0);
      check("rst_ovalid", ovalid, 0);
      check("rst_up_ready", up_ready, 0);
      check("rst_overflow", overflow, 0);
      check("rst_exc", exc_seen, 0);
      rst = 1'b0;
      step();
      check("ready_after_rst", up_ready, 1);
      // fill
      for (int i = 1; i <= 14; i++) begin
         ivalid = 1'b1; idata = {2'b01, 32'(i)};
         step();
         if (i == 13) check("ready_at_13", up_ready, 1);
      end
      check("fill14_count", count, 14);
      check("fill14_ready", up_ready, 0);
      for (int i = 15; i <= 16; i++) begin
         idata = {2'b01, 32'(i)};
         step();
      end
      ivalid = 1'b0;
      check("fill16_count", count, 16);
      check("fill16_overflow", overflow, 0);
      check("fill16_head", odata, 34'h1_0000_0001);
      // overflow
      ivalid = 1'b1; idata = 34'h1_0000_0011;
      step();
      ivalid = 1'b0;
      check("ovf_flag", overflow, 1);
      check("ovf_count", count, 16);
      dn_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("ovf_drain_data", odata, {2'b01, 32'(i)});
         check("ovf_drain_valid", ovalid, 1);
         step();
      end
      check("ovf_drain_empty", ovalid, 0);
      check("ovf_drain_count", count, 0);
      check("ovf_sticky", overflow, 1);
      // latency, dn_ready already 1
      ivalid = 1'b1; idata = 34'h1_447A_0000;
      step();
      ivalid = 1'b0;
      check("lat_ovalid", ovalid, 1);
      check("lat_data", odata, 34'h1_447A_0000);
      check("lat_count1", count, 1);
      step();
      check("lat_count0", count, 0);
      check("lat_exc_clear", exc_seen, 0);
      // exception
      ivalid = 1'b1; idata = 34'h2_7F80_0000;
      step();
      ivalid = 1'b0;
      check("exc_set", exc_seen, 1);
      check("exc_data", odata, 34'h2_7F80_0000);
      step();
      check("exc_drained", count, 0);
      check("exc_sticky", exc_seen, 1);
      // reset mid-operation
      dn_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         ivalid = 1'b1; idata = {2'b01, 32'(8'h40 + i)};
         step();
      end
      ivalid = 1'b0;
      check("mid_count7", count, 7);
      rst = 1'b1;
      step();
      check("mid_rst_count", count, 0);
      check("mid_rst_ovalid", ovalid, 0);
      check("mid_rst_ready", up_ready, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_exc", exc_seen, 0);
      rst = 1'b0;
      step();
      check("mid_ready_back", up_ready, 1);
      check("mid_still_empty", ovalid, 0);
      // full pass-through
      for (int i = 0; i < 16; i++) begin
         ivalid = 1'b1; idata = {2'b01, 32'(8'h20 + i)};
         step();
      end
      check("pt_full", count, 16);
      dn_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         idata = {2'b01, 32'(8'h30 + k)};
         check("pt_data", odata, {2'b01, 32'(8'h20 + k)});
         step();
         check("pt_count", count, 16);
         check("pt_overflow", overflow, 0);
      end
      ivalid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("pt_drain_data", odata, {2'b01, 32'(8'h25 + i)});
         step();
      end
      check("pt_empty", ovalid, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
